// File: rtl/condicionador_botao.sv
// condicionador_botao: push-button conditioner.
// Debounces the raw button level and measures the hold length of each press.
// Emits a short-press strobe on release, or a long-press strobe while the
// button is still held.
// Optional build macro CONDICIONADOR_SYNC_EN puts a 2-flop synchronizer in
// front of the FSM, which adds 2 cycles of latency. Without the macro the
// button level is sampled directly, so it must already be synchronous to clk.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   SOLTO       | released, idle
//   FILT_PRESS  | counting consecutive pressed samples before acceptance
//   PRESSIONADO | accepted press, hold counter running, not yet long
//   LONGO       | long press already signalled, hold counter still running
//   FILT_SOLTA  | counting consecutive released samples, hold counter frozen
module condicionador_botao #(
    parameter int DEBOUNCE_T = 20,
    parameter int LONG_T     = 5300,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_button,
    output logic             btn_db,
    output logic             pulso_curto,
    output logic             pulso_longo,
    output logic [CNT_W-1:0] duracao
);

    localparam int FILT_W = (DEBOUNCE_T < 2) ? 1 : $clog2(DEBOUNCE_T + 1);
    localparam logic [FILT_W-1:0] FILT_LIM = FILT_W'(DEBOUNCE_T);

    // If LONG_T is at or above the counter ceiling, a long press can never qualify.
    localparam longint HOLD_MAX       = (longint'(1) << CNT_W) - 1;
    localparam bit     LONG_REACHABLE = longint'(LONG_T) < HOLD_MAX;
    localparam logic [CNT_W-1:0] LONG_LIM = LONG_REACHABLE ? CNT_W'(LONG_T) : '1;

    typedef enum logic [2:0] {
        SOLTO       = 3'd0,
        FILT_PRESS  = 3'd1,
        PRESSIONADO = 3'd2,
        LONGO       = 3'd3,
        FILT_SOLTA  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              longo_q, longo_d;
    logic              btn_db_d, pulso_curto_d, pulso_longo_d;
    logic [CNT_W-1:0]  duracao_d;

    logic              s;
    logic [FILT_W-1:0] filt_inc;
    logic [CNT_W-1:0]  hold_inc;
    logic              long_hit;

`ifdef CONDICIONADOR_SYNC_EN
    logic [1:0] sync_ff;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], push_button};
        end
    end

    assign s = sync_ff[1];
`else
    assign s = push_button;
`endif

    assign filt_inc = filt_q + 1'b1;
    assign hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    assign long_hit = LONG_REACHABLE && (hold_inc > LONG_LIM);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SOLTO;
            filt_q      <= '0;
            hold_q      <= '0;
            longo_q     <= 1'b0;
            btn_db      <= 1'b0;
            pulso_curto <= 1'b0;
            pulso_longo <= 1'b0;
            duracao     <= '0;
        end else begin
            state_q     <= state_d;
            filt_q      <= filt_d;
            hold_q      <= hold_d;
            longo_q     <= longo_d;
            btn_db      <= btn_db_d;
            pulso_curto <= pulso_curto_d;
            pulso_longo <= pulso_longo_d;
            duracao     <= duracao_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state_q;
        filt_d        = filt_q;
        hold_d        = hold_q;
        longo_d       = longo_q;
        btn_db_d      = btn_db;
        pulso_curto_d = 1'b0;
        pulso_longo_d = 1'b0;
        duracao_d     = duracao;

        case (state_q)
            SOLTO: begin
                if (s) begin
                    if (DEBOUNCE_T <= 1) begin
                        state_d  = PRESSIONADO;
                        filt_d   = '0;
                        hold_d   = '0;
                        longo_d  = 1'b0;
                        btn_db_d = 1'b1;
                    end else begin
                        state_d = FILT_PRESS;
                        filt_d  = FILT_W'(1);
                    end
                end
            end

            FILT_PRESS: begin
                if (!s) begin
                    state_d = SOLTO;
                    filt_d  = '0;
                end else if (filt_inc == FILT_LIM) begin
                    state_d  = PRESSIONADO;
                    filt_d   = '0;
                    hold_d   = '0;
                    longo_d  = 1'b0;
                    btn_db_d = 1'b1;
                end else begin
                    filt_d = filt_inc;
                end
            end

            PRESSIONADO, LONGO: begin
                if (s) begin
                    hold_d = hold_inc;
                    if (state_q == PRESSIONADO && long_hit) begin
                        state_d       = LONGO;
                        longo_d       = 1'b1;
                        pulso_longo_d = 1'b1;
                    end
                end else if (DEBOUNCE_T <= 1) begin
                    state_d       = SOLTO;
                    filt_d        = '0;
                    btn_db_d      = 1'b0;
                    duracao_d     = hold_q;
                    pulso_curto_d = !longo_q;
                    longo_d       = 1'b0;
                end else begin
                    state_d = FILT_SOLTA;
                    filt_d  = FILT_W'(1);
                end
            end

            FILT_SOLTA: begin
                if (s) begin
                    // Release glitch rejected: go back to where the press was.
                    state_d = longo_q ? LONGO : PRESSIONADO;
                    filt_d  = '0;
                end else if (filt_inc == FILT_LIM) begin
                    state_d       = SOLTO;
                    filt_d        = '0;
                    btn_db_d      = 1'b0;
                    duracao_d     = hold_q;
                    pulso_curto_d = !longo_q;
                    longo_d       = 1'b0;
                end else begin
                    filt_d = filt_inc;
                end
            end

            default: begin
                state_d = SOLTO;
                filt_d  = '0;
                hold_d  = '0;
                longo_d = 1'b0;
            end
        endcase
    end

endmodule
